// File: rtl/matvec_scheduler.sv
// Sequences the 2x2 inverse-Jacobian product through one shared multiplier and one shared adder.
// Operands and results pass through bit-exact; a per-WAIT watchdog aborts a run if a unit never answers.
`timescale 1ns/1ps
module matvec_scheduler #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] dx,
  input  logic [63:0] dy,
  input  logic [63:0] invA,
  input  logic [63:0] invB,
  input  logic [63:0] invC,
  input  logic [63:0] invD,
  output logic        mul_start,
  output logic [63:0] mul_a,
  output logic [63:0] mul_b,
  input  logic        mul_done,
  input  logic [63:0] mul_result,
  output logic        add_start,
  output logic [63:0] add_a,
  output logic [63:0] add_b,
  input  logic        add_done,
  input  logic [63:0] add_result,
  output logic        busy,
  output logic        data_ready,
  output logic        error,
  output logic [63:0] dth1,
  output logic [63:0] dth2
);
  localparam int DATA_W = 64;
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, IS_MD, WT_MD, IS_MC, WT_MC, IS_A1, WT_A1,
    IS_MB, WT_MB, IS_MA, WT_MA, IS_A2, WT_A2, DONE
  } state_e;

  state_e state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [DATA_W-1:0] dx_q, dy_q, inva_q, invb_q, invc_q, invd_q;
  logic [DATA_W-1:0] p0_q, p1_q, stg1_q, dth1_q, dth2_q;
  logic wait_mul, wait_add, unit_done, wd_hit, accept;

  assign wait_mul  = state_q inside {WT_MD, WT_MC, WT_MB, WT_MA};
  assign wait_add  = state_q inside {WT_A1, WT_A2};
  assign unit_done = (wait_mul & mul_done) | (wait_add & add_done);
  assign wd_hit    = (wait_mul | wait_add) & ~unit_done & (wd_q == WD_LAST);
  // DONE also accepts start so back-to-back runs keep busy high.
  assign accept    = start & ((state_q == IDLE) | (state_q == DONE));
  assign wd_d      = (wait_mul | wait_add) ? (unit_done ? wd_q : wd_q + WD_W'(1)) : '0;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = IS_MD;
      IS_MD: state_d = WT_MD;
      WT_MD: if (mul_done) state_d = IS_MC;
      IS_MC: state_d = WT_MC;
      WT_MC: if (mul_done) state_d = IS_A1;
      IS_A1: state_d = WT_A1;
      WT_A1: if (add_done) state_d = IS_MB;
      IS_MB: state_d = WT_MB;
      WT_MB: if (mul_done) state_d = IS_MA;
      IS_MA: state_d = WT_MA;
      WT_MA: if (mul_done) state_d = IS_A2;
      IS_A2: state_d = WT_A2;
      WT_A2: if (add_done) state_d = DONE;
      DONE:  state_d = start ? IS_MD : IDLE;
      default: state_d = IDLE;
    endcase
    if (wd_hit) state_d = IDLE;
  end

  always_comb begin
    mul_start  = state_q inside {IS_MD, IS_MC, IS_MB, IS_MA};
    add_start  = state_q inside {IS_A1, IS_A2};
    busy       = (state_q != IDLE);
    data_ready = (state_q == DONE);
    error      = wd_hit;
    mul_a = '0;
    mul_b = '0;
    add_a = '0;
    add_b = '0;
    unique case (state_q)
      IS_MD, WT_MD: begin mul_a = dx_q; mul_b = invd_q; end
      IS_MC, WT_MC: begin mul_a = dy_q; mul_b = invc_q; end
      IS_MB, WT_MB: begin mul_a = dx_q; mul_b = invb_q; end
      IS_MA, WT_MA: begin mul_a = dy_q; mul_b = inva_q; end
      IS_A1, WT_A1: begin add_a = p0_q; add_b = p1_q; end
      IS_A2, WT_A2: begin add_a = p1_q; add_b = p0_q; end
      default: ;
    endcase
  end

  // Visible results: both words update together on entry to DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q   <= '0;
      dth1_q <= '0;
      dth2_q <= '0;
    end else begin
      wd_q <= wd_d;
      if (state_q == WT_A2 && add_done) begin
        dth1_q <= stg1_q;
        dth2_q <= add_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      dx_q   <= dx;
      dy_q   <= dy;
      inva_q <= invA;
      invb_q <= invB;
      invc_q <= invC;
      invd_q <= invD;
    end
    unique case (state_q)
      WT_MD: if (mul_done) p0_q <= mul_result;
      WT_MC: if (mul_done) p1_q <= mul_result;
      WT_A1: if (add_done) stg1_q <= add_result;
      WT_MB: if (mul_done) p0_q <= mul_result;
      WT_MA: if (mul_done) p1_q <= mul_result;
      default: ;
    endcase
  end

  assign dth1 = dth1_q;
  assign dth2 = dth2_q;
endmodule
